// File: rtl/ftdi_pkg.sv
// Shared definitions for the FTDI FIFO bridge: bus width, FSM state encoding and helpers.
package ftdi_pkg;

    localparam int unsigned BUS_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_STROBE,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_GAP
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with registered level/full/empty; a push while full is
// accepted only together with a pop so the level stays put.
module sync_byte_fifo
    import ftdi_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  logic [BUS_W-1:0]         push_data,
    input  logic                     pop,
    output logic [BUS_W-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [BUS_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_en;
    logic             pop_en;

    always_comb begin
        pop_en   = pop && !empty_q;
        push_en  = push && (!full_q || pop_en);
        wr_ptr_d = wr_ptr_q + AW'(push_en);
        rd_ptr_d = rd_ptr_q + AW'(pop_en);
        level_d  = level_q + LW'(push_en) - LW'(pop_en);
        full_d   = (level_d == LW'(DEPTH));
        empty_d  = (level_d == '0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/ftdi_fifo_bridge.sv
// Bridges host byte streams to an FTDI async FIFO bus (rxf/txe/rd/wr/dq) with
// round-robin arbitration between reads and writes and registered bus strobes.
module ftdi_fifo_bridge
    import ftdi_pkg::*;
#(
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RD_PULSE = 3,
    parameter int unsigned WR_PULSE = 2,
    parameter int unsigned GAP      = 2
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        rxf,
    input  logic                        txe,
    output logic                        rd,
    output logic                        wr,
    inout  wire  [BUS_W-1:0]            dq,
    input  logic [BUS_W-1:0]            tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [BUS_W-1:0]            rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level
);

    localparam int unsigned MAX_CNT = max3(RD_PULSE, WR_PULSE, GAP);
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    logic [1:0]       rxf_sync_q, rxf_sync_d;
    logic [1:0]       txe_sync_q, txe_sync_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             oe_q, oe_d;
    logic [BUS_W-1:0] dout_q, dout_d;
    logic             last_wr_q, last_wr_d;

    logic             rxf_s, txe_s;
    logic             read_ok, write_ok, grant_rd, grant_wr;
    logic             rx_push, tx_pop, tx_push, rx_pop;
    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic [BUS_W-1:0] tx_head;

    assign rxf_s    = rxf_sync_q[1];
    assign txe_s    = txe_sync_q[1];
    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign tx_push  = tx_valid && !tx_full;
    assign rx_pop   = rx_ready && !rx_empty;

    sync_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .level     (tx_level),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    sync_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (rx_push),
        .push_data (dq),
        .pop       (rx_pop),
        .pop_data  (rx_data),
        .level     (rx_level),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // Next-state logic; strobes and output enable are decoded from the next state so they leave flops.
    always_comb begin
        rxf_sync_d = {rxf_sync_q[0], rxf};
        txe_sync_d = {txe_sync_q[0], txe};
        state_d    = state_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        last_wr_d  = last_wr_q;
        rx_push    = 1'b0;
        tx_pop     = 1'b0;

        read_ok  = !rxf_s && !rx_full;
        write_ok = !txe_s && !tx_empty;
        grant_rd = read_ok && (!write_ok || last_wr_q);
        grant_wr = write_ok && !grant_rd;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_rd) begin
                    state_d   = ST_RD_STROBE;
                    cnt_d     = CNT_W'(RD_PULSE - 1);
                    last_wr_d = 1'b0;
                end else if (grant_wr) begin
                    state_d   = ST_WR_SETUP;
                    cnt_d     = '0;
                    dout_d    = tx_head;
                    last_wr_d = 1'b1;
                end
            end
            ST_RD_STROBE: begin
                if (cnt_q == '0) begin
                    rx_push = 1'b1;
                    state_d = ST_GAP;
                    cnt_d   = CNT_W'(GAP - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_STROBE;
                cnt_d   = CNT_W'(WR_PULSE - 1);
            end
            ST_WR_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                tx_pop  = 1'b1;
                state_d = ST_GAP;
                cnt_d   = CNT_W'(GAP - 1);
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        rd_d = (state_d != ST_RD_STROBE);
        wr_d = (state_d != ST_WR_STROBE);
        oe_d = (state_d == ST_WR_SETUP) || (state_d == ST_WR_STROBE) || (state_d == ST_WR_HOLD);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rxf_sync_q <= 2'b11;
            txe_sync_q <= 2'b11;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_q       <= 1'b1;
            wr_q       <= 1'b1;
            oe_q       <= 1'b0;
            dout_q     <= '0;
            last_wr_q  <= 1'b1;
        end else begin
            rxf_sync_q <= rxf_sync_d;
            txe_sync_q <= txe_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
            last_wr_q  <= last_wr_d;
        end
    end

    assign rd = rd_q;
    assign wr = wr_q;
    assign dq = oe_q ? dout_q : {BUS_W{1'bz}};

endmodule

// File: doc/ftdi_fifo_bridge.md
FTDI_FIFO_BRIDGE -- requirements
Module: ftdi_fifo_bridge

Interface
REQ-001 Parameter RX_DEPTH, default 16: rx buffer depth in bytes, power of two, >= 2.
REQ-002 Parameter TX_DEPTH, default 16: tx buffer depth in bytes, power of two, >= 2.
REQ-003 Parameter RD_PULSE, default 3: rd low time in clk cycles, >= 2.
REQ-004 Parameter WR_PULSE, default 2: wr low time in clk cycles, >= 1.
REQ-005 Parameter GAP, default 2: idle cycles between bus transactions, >= 1.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 n_rst  in  1  asynchronous, active-low reset.
REQ-008 rxf  in  1  FTDI receive-data-available, active-low, asynchronous to clk.
REQ-009 txe  in  1  FTDI transmit-space-available, active-low, asynchronous to clk.
REQ-010 rd  out  1  FTDI read strobe, active-low.
REQ-011 wr  out  1  FTDI write strobe, active-low.
REQ-012 dq  inout  8  FTDI data bus; driven only during write phases, otherwise Hi-Z.
REQ-013 tx_data / tx_valid / tx_ready  in/in/out  8/1/1  host-to-FTDI byte stream, valid/ready.
REQ-014 rx_data / rx_valid / rx_ready  out/out/in  8/1/1  FTDI-to-host byte stream, valid/ready.
REQ-015 tx_level / rx_level  out  clog2(DEPTH)+1 each  current occupancy of each buffer.

Function
REQ-016 rxf and txe SHALL each pass a 2-flop synchroniser; all decisions use the synchronised copies rxf_s and txe_s.
REQ-017 tx buffer SHALL push on tx_valid&tx_ready; tx_ready = (tx_level != TX_DEPTH).
REQ-018 rx buffer SHALL present its head on rx_data with rx_valid = (rx_level != 0); it pops on rx_valid&rx_ready.
REQ-019 Simultaneous push and pop on one buffer SHALL leave its level unchanged; pointers wrap modulo depth.
REQ-020 FSM states: IDLE, RD_STROBE, WR_SETUP, WR_STROBE, WR_HOLD, GAP.
REQ-021 IDLE: read_ok = !rxf_s & (rx_level != RX_DEPTH); write_ok = !txe_s & (tx_level != 0).
REQ-022 If only one of read_ok/write_ok holds, grant it. If both hold, grant the opposite of the last granted direction (round-robin); after reset the last grant is write, so read wins first.
REQ-023 RD_STROBE: rd = 0 for exactly RD_PULSE cycles; dq sampled on the last cycle and pushed into the rx buffer; then GAP.
REQ-024 WR_SETUP: 1 cycle; dq driven with the tx head, wr = 1.
REQ-025 WR_STROBE: wr = 0 for WR_PULSE cycles; dq stays driven.
REQ-026 WR_HOLD: 1 cycle, wr = 1, dq still driven; tx head popped on this cycle; then GAP.
REQ-027 GAP: GAP cycles with rd = wr = 1 and dq Hi-Z; then IDLE.
REQ-028 rd and wr SHALL never be low in the same cycle; dq SHALL never be driven while rd = 0.
REQ-029 rxf/txe deasserting mid-transaction SHALL NOT abort it; the transaction completes.
REQ-030 A single pulse-width counter SHALL serve all timed states and reload on every state entry.
REQ-031 rd, wr, and the dq output enable SHALL be registered outputs (glitch-free).
REQ-032 Minimum cycles per byte: read = RD_PULSE + GAP + 1; write = 3 + WR_PULSE + GAP.

Reset
REQ-033 While n_rst = 0: FSM = IDLE, rd = wr = 1, dq Hi-Z, both buffers empty, tx_ready = 1, rx_valid = 0, levels = 0, synchronisers = 1, last grant = write.
REQ-034 Reset asserted mid-transaction SHALL release rd, wr, and dq immediately (asynchronously); buffered data is discarded.

Structure
REQ-035 A shared package ftdi_pkg SHALL hold the FSM state encoding and the FTDI bus width constant (8).
REQ-036 Both buffers SHALL be instances of one sub-module, sync_byte_fifo (parameter DEPTH; push/pop/level/full/empty).

Verification
REQ-037 Reset: hold n_rst = 0 during RD_STROBE -> rd = 1 and dq Hi-Z in the same cycle; rx_level = 0.
REQ-038 Read burst: defaults; FTDI model holds rxf low with bytes 0x11, 0x22, 0x33 -> rx stream delivers 11, 22, 33 in order; each rd low exactly 3 cycles.
REQ-039 Write: push 0xA5, 0x5A; txe low -> dq = A5 stable from WR_SETUP through WR_HOLD; wr low exactly 2 cycles; tx_level reaches 0.
REQ-040 Arbitration: both directions pending continuously -> grants alternate R, W, R, W; rd and wr never overlap.
REQ-041 Full rx: rx_ready = 0, RX_DEPTH = 4, rxf low -> exactly 4 reads, then rd stays 1; one pop -> exactly one more read.
REQ-042 Backpressure: txe high with 16 bytes pushed -> tx_ready = 0, tx_level = 16, wr stays 1; txe low -> 16 writes in order.
